// File: rtl/pll_cfg_pkg.sv
// Shared types for the PLL reconfiguration sequencer: FSM states, divider
// profiles for the Gowin rPLL and its inverted dynamic-select encoding.
package pll_cfg_pkg;

  typedef enum logic [2:0] {
    RST_HOLD   = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE_CHK = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } state_e;

  typedef struct packed {
    logic [5:0] idiv;
    logic [5:0] fbdiv;
    logic [5:0] odiv;
  } profile_t;

  // Static divider values; entry 0 is the 18 MHz in -> 54 MHz build default.
  function automatic profile_t profile_lookup(input logic [1:0] idx);
    profile_t p;
    case (idx)
      2'd0:    p = '{idiv: 6'd0, fbdiv: 6'd2, odiv: 6'd8};
      2'd1:    p = '{idiv: 6'd0, fbdiv: 6'd5, odiv: 6'd8};
      2'd2:    p = '{idiv: 6'd1, fbdiv: 6'd8, odiv: 6'd4};
      default: p = '{idiv: 6'd0, fbdiv: 6'd3, odiv: 6'd2};
    endcase
    return p;
  endfunction

  function automatic logic [5:0] encode_sel(input logic [5:0] x);
    return 6'd63 - x;
  endfunction

  function automatic profile_t encode_profile(input profile_t p);
    profile_t e;
    e.idiv  = encode_sel(p.idiv);
    e.fbdiv = encode_sel(p.fbdiv);
    e.odiv  = encode_sel(p.odiv);
    return e;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer for the raw PLL LOCK plus a consecutive-high counter
// that flags lock_stable on the LOCK_STABLE-th synchronized high while enabled.
module lock_sync #(
  parameter int LOCK_STABLE = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic clr,
  output logic lock_s,
  output logic lock_stable
);

  localparam int SW = $clog2(LOCK_STABLE + 1);

  logic          meta_q, meta_d;
  logic          lock_s_q, lock_s_d;
  logic [SW-1:0] stab_q, stab_d;

  always_comb begin
    meta_d      = pll_lock;
    lock_s_d    = meta_q;
    lock_stable = lock_s_q && !clr && (stab_q == SW'(LOCK_STABLE - 1));
    stab_d      = '0;
    if (lock_s_q && !clr) stab_d = stab_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      lock_s_q <= 1'b0;
      stab_q   <= '0;
    end else begin
      meta_q   <= meta_d;
      lock_s_q <= lock_s_d;
      stab_q   <= stab_d;
    end
  end

  assign lock_s = lock_s_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rPLL sequencer on the reference clock: select load, reset pulse, lock wait with retry.
// Optional LOCK_LOSS_RECOVER_EN: two low lock_s cycles in RUN force a relock.
module pll_reconfig_ctrl
  import pll_cfg_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RETRY    = 3,
  parameter int BOOT_PROFILE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_profile,
  output logic       req_ready,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic [1:0] cur_profile,
  output logic       clk_ok,
  output logic       sys_rst_n,
  output logic       fault
);

  localparam int CMAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam int RW   = $clog2(MAX_RETRY + 2);
  localparam profile_t BOOT_SEL = encode_profile(profile_lookup(2'(BOOT_PROFILE)));

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic          pll_reset_q, pll_reset_d;
  logic          clk_ok_q, clk_ok_d;
  logic          sys_rst_n_q, sys_rst_n_d;
  logic          fault_q, fault_d;
  logic          req_ready_q, req_ready_d;
  logic [1:0]    cur_profile_q, cur_profile_d;
  profile_t      sel_q, sel_d;
  logic          lock_s, lock_stable, accept;
`ifdef LOCK_LOSS_RECOVER_EN
  logic          lost_q, lost_d;
`endif

  lock_sync #(.LOCK_STABLE(LOCK_STABLE)) u_lock_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .clr        (state_q != STABLE_CHK),
    .lock_s     (lock_s),
    .lock_stable(lock_stable)
  );

  assign accept = req_valid && req_ready_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_cnt_d   = retry_cnt_q;
    pll_reset_d   = pll_reset_q;
    clk_ok_d      = clk_ok_q;
    sys_rst_n_d   = sys_rst_n_q;
    fault_d       = fault_q;
    cur_profile_d = cur_profile_q;
    sel_d         = sel_q;
`ifdef LOCK_LOSS_RECOVER_EN
    lost_d        = (state_q == RUN) && !lock_s;
`endif
    case (state_q)
      RST_HOLD: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          pll_reset_d = 1'b0;
          cnt_d       = '0;
          state_d     = WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          cnt_d   = '0;
          state_d = STABLE_CHK;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          cnt_d       = '0;
          pll_reset_d = 1'b1;
          if (retry_cnt_q == RW'(MAX_RETRY)) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            retry_cnt_d = retry_cnt_q + RW'(1);
            state_d     = RST_HOLD;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_CHK: begin
        if (!lock_s) begin
          cnt_d   = '0;
          state_d = WAIT_LOCK;
        end else if (lock_stable) begin
          clk_ok_d    = 1'b1;
          sys_rst_n_d = 1'b1;
          retry_cnt_d = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
`ifdef LOCK_LOSS_RECOVER_EN
        if (lost_q && !lock_s) begin
          clk_ok_d    = 1'b0;
          sys_rst_n_d = 1'b0;
          pll_reset_d = 1'b1;
          cnt_d       = '0;
          state_d     = RST_HOLD;
        end
`endif
      end
      FAULT: begin
        pll_reset_d = 1'b1;
        clk_ok_d    = 1'b0;
        sys_rst_n_d = 1'b0;
      end
      default: state_d = RST_HOLD;
    endcase
    // A request wins over any lock event seen in the same cycle.
    if (accept) begin
      cur_profile_d = req_profile;
      sel_d         = encode_profile(profile_lookup(req_profile));
      clk_ok_d      = 1'b0;
      sys_rst_n_d   = 1'b0;
      pll_reset_d   = 1'b1;
      fault_d       = 1'b0;
      retry_cnt_d   = '0;
      cnt_d         = '0;
      state_d       = RST_HOLD;
    end
    req_ready_d = (state_d == RUN) || (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RST_HOLD;
      cnt_q         <= '0;
      retry_cnt_q   <= '0;
      pll_reset_q   <= 1'b1;
      clk_ok_q      <= 1'b0;
      sys_rst_n_q   <= 1'b0;
      fault_q       <= 1'b0;
      req_ready_q   <= 1'b0;
      cur_profile_q <= 2'(BOOT_PROFILE);
      sel_q         <= BOOT_SEL;
`ifdef LOCK_LOSS_RECOVER_EN
      lost_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_cnt_q   <= retry_cnt_d;
      pll_reset_q   <= pll_reset_d;
      clk_ok_q      <= clk_ok_d;
      sys_rst_n_q   <= sys_rst_n_d;
      fault_q       <= fault_d;
      req_ready_q   <= req_ready_d;
      cur_profile_q <= cur_profile_d;
      sel_q         <= sel_d;
`ifdef LOCK_LOSS_RECOVER_EN
      lost_q        <= lost_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign pll_reset   = pll_reset_q;
  assign pll_idsel   = sel_q.idiv;
  assign pll_fbdsel  = sel_q.fbdiv;
  assign pll_odsel   = sel_q.odiv;
  assign cur_profile = cur_profile_q;
  assign clk_ok      = clk_ok_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl; the lock-loss step follows LOCK_LOSS_RECOVER_EN.
module tb_pll_reconfig_ctrl;
  import pll_cfg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_profile;
  logic       req_ready;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [1:0] cur_profile;
  logic       clk_ok, sys_rst_n, fault;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  pll_reconfig_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_profile(req_profile),
    .req_ready  (req_ready),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_idsel  (pll_idsel),
    .pll_fbdsel (pll_fbdsel),
    .pll_odsel  (pll_odsel),
    .cur_profile(cur_profile),
    .clk_ok     (clk_ok),
    .sys_rst_n  (sys_rst_n),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_sel(input string tag, input logic [5:0] i, input logic [5:0] f,
                         input logic [5:0] o);
    chk({tag, "_idsel"}, 32'(pll_idsel), 32'(i));
    chk({tag, "_fbdsel"}, 32'(pll_fbdsel), 32'(f));
    chk({tag, "_odsel"}, 32'(pll_odsel), 32'(o));
  endtask

  // Edges until pll_reset reads low; -1 when the budget runs out.
  task automatic wait_reset_fall(output int cnt);
    cnt = 0;
    while (pll_reset !== 1'b0 && cnt < 10000) begin
      tick(1);
      cnt++;
    end
    if (pll_reset !== 1'b0) cnt = -1;
  endtask

  task automatic wait_clk_ok(output int cnt);
    cnt = 0;
    while (clk_ok !== 1'b1 && cnt < 10000) begin
      tick(1);
      cnt++;
    end
    if (clk_ok !== 1'b1) cnt = -1;
  endtask

  task automatic request(input logic [1:0] p);
    req_valid   = 1'b1;
    req_profile = p;
    tick(1);
    req_valid   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_profile = 2'd0; pll_lock = 1'b0;
    tick(3);
    chk("rst_pll_reset", 32'(pll_reset), 1);
    chk("rst_clk_ok", 32'(clk_ok), 0);
    chk("rst_sys_rst_n", 32'(sys_rst_n), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_cur_profile", 32'(cur_profile), 0);
    chk_sel("rst", 6'd63, 6'd61, 6'd55);

    // Power-up: reset pulse, lock 100 cycles later, 2 sync + 64 stable.
    @(negedge clk) rst_n = 1'b1;
    wait_reset_fall(n);
    chk("boot_reset_len", 32'(n), 16);
    tick(100);
    pll_lock = 1'b1;
    wait_clk_ok(n);
    chk("boot_lock_lat", 32'(n), 67);
    chk("boot_sys_rst_n", 32'(sys_rst_n), 1);
    chk("boot_req_ready", 32'(req_ready), 1);
    chk("boot_pll_reset", 32'(pll_reset), 0);

    // Profile change to 2 from RUN.
    pll_lock = 1'b0;
    request(2'd2);
    chk("req2_clk_ok", 32'(clk_ok), 0);
    chk("req2_sys_rst_n", 32'(sys_rst_n), 0);
    chk("req2_req_ready", 32'(req_ready), 0);
    chk("req2_pll_reset", 32'(pll_reset), 1);
    chk("req2_cur_profile", 32'(cur_profile), 2);
    chk_sel("req2", 6'd62, 6'd55, 6'd59);
    wait_reset_fall(n);
    chk("req2_reset_len", 32'(n), 16);
    chk_sel("req2_fall", 6'd62, 6'd55, 6'd59);
    pll_lock = 1'b1;
    wait_clk_ok(n);
    chk("req2_lock_lat", 32'(n), 67);

    // Lock dropped for 3 cycles while in RUN.
    pll_lock = 1'b0;
    tick(3);
    chk("loss_clk_ok_early", 32'(clk_ok), 1);
    pll_lock = 1'b1;
    tick(1);
`ifdef LOCK_LOSS_RECOVER_EN
    chk("loss_clk_ok", 32'(clk_ok), 0);
    chk("loss_sys_rst_n", 32'(sys_rst_n), 0);
    chk("loss_pll_reset", 32'(pll_reset), 1);
    wait_reset_fall(n);
    chk("loss_reset_len", 32'(n), 16);
    wait_clk_ok(n);
    chk("loss_relock_lat", 32'(n), 65);
    chk("loss_cur_profile", 32'(cur_profile), 2);
`else
    chk("loss_clk_ok", 32'(clk_ok), 1);
    tick(10);
    chk("loss_clk_ok_late", 32'(clk_ok), 1);
    chk("loss_pll_reset", 32'(pll_reset), 0);
`endif

    // Lock glitch at stable count 40 while relocking to profile 1.
    pll_lock = 1'b0;
    request(2'd1);
    wait_reset_fall(n);
    chk("glitch_reset_len", 32'(n), 16);
    pll_lock = 1'b1;
    tick(41);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(2);
    chk("glitch_state", 32'(dut.state_q), 32'(WAIT_LOCK));
    chk("glitch_clk_ok", 32'(clk_ok), 0);
    chk("glitch_retry", 32'(dut.retry_cnt_q), 0);
    wait_clk_ok(n);
    chk("glitch_relock_lat", 32'(n), 65);
    chk_sel("prof1", 6'd63, 6'd58, 6'd55);

    // Never locks: four 4096-cycle timeouts, then FAULT.
    pll_lock = 1'b0;
    request(2'd3);
    tick(16);
    chk("nolock_first_fall", 32'(pll_reset), 0);
    tick(4096);
    chk("nolock_retry1_reset", 32'(pll_reset), 1);
    chk("nolock_retry1_fault", 32'(fault), 0);
    tick(12335);
    chk("nolock_before_fault", 32'(fault), 0);
    chk("nolock_before_reset", 32'(pll_reset), 0);
    tick(1);
    chk("nolock_fault", 32'(fault), 1);
    chk("nolock_pll_reset", 32'(pll_reset), 1);
    chk("nolock_req_ready", 32'(req_ready), 1);
    tick(20);
    chk("fault_held", 32'(fault), 1);
    chk("fault_reset_held", 32'(pll_reset), 1);
    chk("fault_clk_ok", 32'(clk_ok), 0);
    chk_sel("prof3", 6'd63, 6'd60, 6'd61);

    // Request from FAULT clears it and relocks to profile 0.
    pll_lock = 1'b1;
    request(2'd0);
    chk("clr_fault", 32'(fault), 0);
    chk("clr_pll_reset", 32'(pll_reset), 1);
    chk("clr_cur_profile", 32'(cur_profile), 0);
    chk_sel("clr", 6'd63, 6'd61, 6'd55);
    wait_reset_fall(n);
    chk("clr_reset_len", 32'(n), 16);
    wait_clk_ok(n);
    chk("clr_lock_lat", 32'(n), 65);

    // Async reset in WAIT_LOCK restores reset values and boots profile 0.
    pll_lock = 1'b0;
    request(2'd2);
    wait_reset_fall(n);
    tick(30);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pll_reset", 32'(pll_reset), 1);
    chk("arst_cur_profile", 32'(cur_profile), 0);
    chk("arst_clk_ok", 32'(clk_ok), 0);
    chk("arst_req_ready", 32'(req_ready), 0);
    chk("arst_fault", 32'(fault), 0);
    chk_sel("arst", 6'd63, 6'd61, 6'd55);
    @(negedge clk) rst_n = 1'b1;
    wait_reset_fall(n);
    chk("arst_reset_len", 32'(n), 16);
    pll_lock = 1'b1;
    wait_clk_ok(n);
    chk("arst_lock_lat", 32'(n), 67);
    chk("arst_final_profile", 32'(cur_profile), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
